// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter mapping NUM_REQ read requesters onto NUM_PORTS register file read ports.
// Optional feature macro RFARB_FORWARD_EN: same-cycle write data is forwarded instead of stalling the read.
module regfile_read_arbiter #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 64,
  parameter int NUM_REQ   = 6,
  parameter int NUM_PORTS = 2,
  parameter int NUM_WRITE = 4,
  localparam int AW       = $clog2(SIZE)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  IN_req,
  input  logic [NUM_REQ-1:0][AW-1:0]          IN_raddr,
  output logic [NUM_REQ-1:0]                  OUT_gnt,
  output logic [NUM_REQ-1:0]                  OUT_rvalid,
  output logic [NUM_REQ-1:0][WIDTH-1:0]       OUT_rdata,
  output logic [NUM_PORTS-1:0]                OUT_re,
  output logic [NUM_PORTS-1:0][AW-1:0]        OUT_raddr,
  input  logic [NUM_PORTS-1:0][WIDTH-1:0]     IN_rdata,
  input  logic [NUM_WRITE-1:0]                IN_we,
  input  logic [NUM_WRITE-1:0][AW-1:0]        IN_waddr,
  input  logic [NUM_WRITE-1:0][WIDTH-1:0]     IN_wdata
);

  localparam int PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW   = PTRW + 1;
  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PCW  = $clog2(NUM_PORTS + 1);

  logic [PTRW-1:0]                ptr_q, ptr_d;
  logic [NUM_REQ-1:0]             rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0][PW-1:0]     port_q, port_d;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_PORTS-1:0]           re;
  logic [NUM_PORTS-1:0][AW-1:0]   raddr_o;

`ifdef RFARB_FORWARD_EN
  logic [NUM_REQ-1:0]             fwd_hit_q, fwd_hit_d;
  logic [NUM_REQ-1:0][WIDTH-1:0]  fwd_data_q, fwd_data_d;
`else
  logic unused_wdata;
  assign unused_wdata = ^IN_wdata;
`endif

  // Scan from ptr; the k-th winner takes port k. Ascending j lets the highest write index win.
  always_comb begin
    logic [SW-1:0]    sum;
    logic [PTRW-1:0]  idx;
    logic [PCW-1:0]   cnt;
    logic             coll;
    logic             blocked;
`ifdef RFARB_FORWARD_EN
    logic [WIDTH-1:0] coll_data;
    fwd_hit_d  = '0;
    fwd_data_d = '0;
    coll_data  = '0;
`endif
    gnt     = '0;
    re      = '0;
    raddr_o = '0;
    port_d  = '0;
    ptr_d   = ptr_q;
    cnt     = '0;
    sum     = '0;
    idx     = '0;
    coll    = 1'b0;
    blocked = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = SW'(ptr_q) + SW'(i);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      idx  = sum[PTRW-1:0];
      coll = 1'b0;
`ifdef RFARB_FORWARD_EN
      coll_data = '0;
`endif
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (IN_we[j] && (IN_waddr[j] == IN_raddr[idx])) begin
          coll = 1'b1;
`ifdef RFARB_FORWARD_EN
          coll_data = IN_wdata[j];
`endif
        end
      end
`ifdef RFARB_FORWARD_EN
      blocked = 1'b0;
`else
      blocked = coll;
`endif
      if (IN_req[idx] && !blocked && (cnt < PCW'(NUM_PORTS))) begin
        gnt[idx] = 1'b1;
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (cnt == PCW'(k)) begin
            re[k]       = 1'b1;
            raddr_o[k]  = IN_raddr[idx];
            port_d[idx] = PW'(k);
          end
        end
`ifdef RFARB_FORWARD_EN
        fwd_hit_d[idx]  = coll;
        fwd_data_d[idx] = coll_data;
`endif
        ptr_d = (idx == PTRW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        cnt   = cnt + 1'b1;
      end
    end
  end

  assign rvalid_d = gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      port_q   <= '0;
`ifdef RFARB_FORWARD_EN
      fwd_hit_q  <= '0;
      fwd_data_q <= '0;
`endif
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      port_q   <= port_d;
`ifdef RFARB_FORWARD_EN
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
`endif
    end
  end

  // Grant-side outputs are combinational, so they are forced quiet while reset is held.
  assign OUT_gnt    = rst ? '0 : gnt;
  assign OUT_re     = rst ? '0 : re;
  assign OUT_raddr  = rst ? '0 : raddr_o;
  assign OUT_rvalid = rvalid_q;

  always_comb begin
    OUT_rdata = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (rvalid_q[r]) begin
        OUT_rdata[r] = IN_rdata[port_q[r]];
`ifdef RFARB_FORWARD_EN
        if (fwd_hit_q[r]) OUT_rdata[r] = fwd_data_q[r];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed scenarios plus random traffic against a scan-order reference model.
// Builds with or without RFARB_FORWARD_EN; the model follows the same macro.
module tb_regfile_read_arbiter;
  localparam int WIDTH     = 32;
  localparam int SIZE      = 64;
  localparam int NUM_REQ   = 6;
  localparam int NUM_PORTS = 2;
  localparam int NUM_WRITE = 4;
  localparam int AW        = $clog2(SIZE);

  logic                             clk;
  logic                             rst;
  logic [NUM_REQ-1:0]               in_req;
  logic [NUM_REQ-1:0][AW-1:0]       in_raddr;
  logic [NUM_REQ-1:0]               out_gnt;
  logic [NUM_REQ-1:0]               out_rvalid;
  logic [NUM_REQ-1:0][WIDTH-1:0]    out_rdata;
  logic [NUM_PORTS-1:0]             out_re;
  logic [NUM_PORTS-1:0][AW-1:0]     out_raddr;
  logic [NUM_PORTS-1:0][WIDTH-1:0]  in_rdata;
  logic [NUM_WRITE-1:0]             in_we;
  logic [NUM_WRITE-1:0][AW-1:0]     in_waddr;
  logic [NUM_WRITE-1:0][WIDTH-1:0]  in_wdata;

  int total = 0;
  int bad   = 0;

  // reference model state: scan pointer and last cycle's grants
  int                    m_ptr;
  logic [NUM_REQ-1:0]    m_pend;
  int                    m_port [NUM_REQ];
  bit                    m_fwd  [NUM_REQ];
  logic [WIDTH-1:0]      m_fwd_data [NUM_REQ];
  logic [WIDTH-1:0]      exp_q[$];

  regfile_read_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .IN_req     (in_req),
    .IN_raddr   (in_raddr),
    .OUT_gnt    (out_gnt),
    .OUT_rvalid (out_rvalid),
    .OUT_rdata  (out_rdata),
    .OUT_re     (out_re),
    .OUT_raddr  (out_raddr),
    .IN_rdata   (in_rdata),
    .IN_we      (in_we),
    .IN_waddr   (in_waddr),
    .IN_wdata   (in_wdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_pend = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      m_port[r]     = 0;
      m_fwd[r]      = 1'b0;
      m_fwd_data[r] = '0;
    end
  endtask

  task automatic clear_in();
    in_req   = '0;
    in_raddr = '0;
    in_we    = '0;
    in_waddr = '0;
    in_wdata = '0;
    in_rdata = '0;
  endtask

  // Compare this cycle's outputs against the model, then advance the model.
  task automatic model_check();
    int cnt;
    int r;
    bit hit;
    logic [WIDTH-1:0] hd;
    logic [WIDTH-1:0] e;
    logic [NUM_REQ-1:0] eg;
    logic [NUM_PORTS-1:0] ere;
    logic [NUM_PORTS-1:0][AW-1:0] era;
    int n_port [NUM_REQ];
    bit n_fwd [NUM_REQ];
    logic [WIDTH-1:0] n_fd [NUM_REQ];
    int last;

    for (int i = 0; i < NUM_REQ; i++)
      exp_q.push_back(m_pend[i] ? (m_fwd[i] ? m_fwd_data[i] : in_rdata[m_port[i]]) : '0);
    chk("rvalid", 64'(out_rvalid), 64'(m_pend));
    for (int i = 0; i < NUM_REQ; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("rdata%0d", i), 64'(out_rdata[i]), 64'(e));
    end

    cnt = 0; eg = '0; ere = '0; era = '0; last = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_port[i] = 0; n_fwd[i] = 1'b0; n_fd[i] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      r = (m_ptr + i) % NUM_REQ;
      hit = 1'b0; hd = '0;
      for (int j = 0; j < NUM_WRITE; j++)
        if (in_we[j] && in_waddr[j] == in_raddr[r]) begin hit = 1'b1; hd = in_wdata[j]; end
`ifndef RFARB_FORWARD_EN
      if (hit) continue;
`endif
      if (in_req[r] && cnt < NUM_PORTS) begin
        eg[r] = 1'b1;
        ere[cnt] = 1'b1;
        era[cnt] = in_raddr[r];
        n_port[r] = cnt;
        n_fwd[r] = hit;
        n_fd[r] = hd;
        last = r;
        cnt++;
      end
    end
    chk("gnt", 64'(out_gnt), 64'(eg));
    chk("re", 64'(out_re), 64'(ere));
    chk("raddr", 64'(out_raddr), 64'(era));

    m_pend = eg;
    for (int i = 0; i < NUM_REQ; i++) begin
      m_port[i] = n_port[i]; m_fwd[i] = n_fwd[i]; m_fwd_data[i] = n_fd[i];
    end
    if (last >= 0) m_ptr = (last + 1) % NUM_REQ;
  endtask

  // driver: one clock cycle, inputs already applied at the falling edge
  task automatic cyc(input bit use_exp = 1'b0, input logic [NUM_REQ-1:0] exp_g = '0,
                     input string tag = "");
    for (int k = 0; k < NUM_PORTS; k++) in_rdata[k] = $urandom;
    #1;
    if (use_exp) chk(tag, 64'(out_gnt), 64'(exp_g));
    model_check();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    clear_in();
    model_reset();
    rst    = 1'b1;
    in_req = '1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(out_gnt), 64'h0);
    chk("rst_re", 64'(out_re), 64'h0);
    chk("rst_raddr", 64'(out_raddr), 64'h0);
    chk("rst_rvalid", 64'(out_rvalid), 64'h0);
    chk("rst_rdata", 64'(|out_rdata), 64'h0);
    rst = 1'b0;

    // all requesting, distinct addresses
    for (int i = 0; i < NUM_REQ; i++) in_raddr[i] = AW'(10 + i);
    cyc(1'b1, 6'b000011, "d29_g0");
    cyc(1'b1, 6'b001100, "d29_g1");
    cyc(1'b1, 6'b110000, "d29_g2");
    cyc(1'b1, 6'b000011, "d29_g3");
    in_req = '0;
    cyc();

    // wrap-around pair shares both ports every cycle
    do_reset();
    in_req = 6'b100001;
    repeat (4) cyc(1'b1, 6'b100001, "d30_g");
    in_req = '0;
    cyc();

    // read/write collision
    do_reset();
    in_req = 6'b000100;
    in_raddr[2] = AW'(7);
    in_we[1] = 1'b1; in_waddr[1] = AW'(7); in_wdata[1] = 32'hDEADBEEF;
`ifdef RFARB_FORWARD_EN
    cyc(1'b1, 6'b000100, "d31_g");
    in_req = '0; in_we = '0;
    #1 chk("d31_fwd", 64'(out_rdata[2]), 64'hDEADBEEF);
    cyc();
`else
    cyc(1'b1, 6'b000000, "d31_blk");
    in_we = '0;
    cyc(1'b1, 6'b000100, "d31_g2");
    in_req = '0;
    cyc();
`endif

    // two writes to one address: higher index wins
    do_reset();
    in_req = 6'b010000;
    in_raddr[4] = AW'(9);
    in_we = 4'b1001;
    in_waddr[0] = AW'(9); in_wdata[0] = 32'h11;
    in_waddr[3] = AW'(9); in_wdata[3] = 32'h33;
    cyc();
    in_req = '0; in_we = '0;
`ifdef RFARB_FORWARD_EN
    #1 chk("d32_fwd", 64'(out_rdata[4]), 64'h33);
`endif
    cyc();

    // asynchronous reset kills the pending response
    do_reset();
    in_req = 6'b001000;
    in_raddr[3] = AW'(3);
    cyc(1'b1, 6'b001000, "d33_g");
    #2 rst = 1'b1;
    #1;
    chk("d33_rvalid", 64'(out_rvalid), 64'h0);
    chk("d33_rdata", 64'(out_rdata[3]), 64'h0);
    chk("d33_gnt", 64'(out_gnt), 64'h0);
    chk("d33_re", 64'(out_re), 64'h0);
    chk("d33_raddr", 64'(out_raddr), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc(1'b1, 6'b001000, "d33_after");
    in_req = '0;
    cyc();

    // lone requester keeps port 0; pointer then sits just past it
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) in_raddr[i] = AW'(20 + i);
    in_req = 6'b010000;
    repeat (10) cyc(1'b1, 6'b010000, "d34_g");
    in_req = '1;
    cyc(1'b1, 6'b100001, "d34_ptr");
    in_req = '0;
    cyc();

    // random traffic; requests hold until granted, small address space forces collisions
    do_reset();
    clear_in();
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < NUM_REQ; r++)
        if (!in_req[r] && $urandom_range(0, 2) == 0) begin
          in_req[r]   = 1'b1;
          in_raddr[r] = AW'($urandom_range(0, 7));
        end
      for (int j = 0; j < NUM_WRITE; j++) begin
        in_we[j]    = ($urandom_range(0, 3) == 0);
        in_waddr[j] = AW'($urandom_range(0, 7));
        in_wdata[j] = $urandom;
      end
      cyc();
      in_req = in_req & ~m_pend;
    end
    clear_in();
    cyc();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_read_arbiter.md
REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 Parameter WIDTH, 32, register data width in bits.
REQ-002 Parameter SIZE, 64, register count; address width AW = $clog2(SIZE).
REQ-003 Parameter NUM_REQ, 6, number of read requesters sharing the ports.
REQ-004 Parameter NUM_PORTS, 2, number of register file read ports arbitrated (NUM_PORTS <= NUM_REQ).
REQ-005 Parameter NUM_WRITE, 4, number of register file write ports snooped.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 IN_req  input  NUM_REQ  per-requester read request, level, held until granted.
REQ-009 IN_raddr  input  NUM_REQ x AW  per-requester read address.
REQ-010 OUT_gnt  output  NUM_REQ  combinational same-cycle grant.
REQ-011 OUT_rvalid  output  NUM_REQ  registered; data valid for requester.
REQ-012 OUT_rdata  output  NUM_REQ x WIDTH  read data for requester.
REQ-013 OUT_re  output  NUM_PORTS  register file read enables.
REQ-014 OUT_raddr  output  NUM_PORTS x AW  register file read addresses.
REQ-015 IN_rdata  input  NUM_PORTS x WIDTH  register file read data, one cycle after OUT_re.
REQ-016 IN_we, IN_waddr, IN_wdata  input  NUM_WRITE, NUM_WRITE x AW, NUM_WRITE x WIDTH  snooped register file write ports.

Function
REQ-017 Each cycle, at most NUM_PORTS requesters with IN_req=1 shall be granted, scanning round-robin from pointer ptr (ptr, ptr+1, ... mod NUM_REQ).
REQ-018 The k-th granted requester in scan order shall drive port k: OUT_re[k]=1, OUT_raddr[k]=IN_raddr[r]; unused ports: OUT_re=0, OUT_raddr=0.
REQ-019 On the edge, ptr shall become (last granted index + 1) mod NUM_REQ; with no grant, ptr is unchanged.
REQ-020 A requester granted in cycle t shall see OUT_rvalid=1 for exactly cycle t+1 with OUT_rdata = IN_rdata of its port; read latency is 1 cycle.
REQ-021 In cycle t+1, OUT_rvalid=0 and OUT_rdata=0 for requesters not granted in cycle t.
REQ-022 A requester may be granted in back-to-back cycles; a grant in t+1 yields a response in t+2 independent of the response in t+1.
REQ-023 Collision: a granted read whose address equals IN_waddr[j] with IN_we[j]=1 in the same cycle is a collision; handling per REQ-027/REQ-028.
REQ-024 Multiple same-cycle writes to one address: the highest index j shall be used.
REQ-025 No request, no grant: OUT_gnt=0 for all requesters with IN_req=0.

Reset
REQ-026 While rst=1: ptr=0, OUT_rvalid=0, OUT_rdata=0, forward registers cleared, OUT_gnt=0, OUT_re=0, OUT_raddr=0; responses for grants in the cycle of reset assertion are dropped; first grant after deassertion scans from requester 0.

Configuration
REQ-027 With RFARB_FORWARD_EN defined: colliding reads shall be granted, and the write data shall be registered and returned in t+1 in place of IN_rdata.
REQ-028 Without RFARB_FORWARD_EN: a colliding request shall not be granted that cycle, shall not consume a port, and shall not affect ptr; scanning continues to the next requester.

Verification
REQ-029 Reset release, IN_req=6'b111111, all addresses distinct, no writes -> grants {0,1}, {2,3}, {4,5}, {0,1}; rvalid one cycle after each grant.
REQ-030 IN_req=6'b100001 every cycle, ptr=0 -> both granted each cycle on ports 0 and 1; rvalid[0] and rvalid[5] high every cycle from the second cycle.
REQ-031 Req 2 reads addr 7 while IN_we[1]=1, IN_waddr[1]=7, IN_wdata[1]=32'hDEADBEEF -> with macro: rdata[2]=32'hDEADBEEF next cycle; without macro: gnt[2]=0 that cycle, granted the next cycle with no write.
REQ-032 Writes j=0 and j=3 both to addr 9 (32'h11, 32'h33) while req 4 reads addr 9, macro defined -> rdata[4]=32'h33.
REQ-033 rst asserted in the cycle after grant to req 3 -> rvalid[3] stays 0, ptr=0, all outputs zero immediately (asynchronous).
REQ-034 Only req 4 active for 10 cycles -> granted every cycle on port 0, port 1 idle (OUT_re[1]=0), ptr=5 afterwards.
